// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU and load result streams in, register-bank write port
// and pending-register mask out.
interface writeback_arbiter_if;
   logic        alu_valid;
   logic        alu_ready;
   logic [3:0]  alu_dest;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [3:0]  ld_dest;
   logic [31:0] ld_data;
   logic        wb_en;
   logic [3:0]  dest;
   logic [31:0] Din;
   logic [15:0] pend_mask;

   modport master (
      output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
      input  alu_ready, ld_ready, wb_en, dest, Din, pend_mask
   );

   modport slave (
      input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
      output alu_ready, ld_ready, wb_en, dest, Din, pend_mask
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with FIFO-buffered load results
// onto the register-bank write port, with WAW kill bits and bounded load starvation.
module writeback_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   writeback_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occupancy;
   logic [AW-1:0]    wr_idx, rd_idx;
   logic [DEPTH-1:0] kill_q, kill_d;
   logic [DEPTH-1:0] live, dest_hit;
   logic [CW-1:0]    starve_q, starve_d;
   logic             wb_en_q, wb_en_d;
   logic [3:0]       dest_q, dest_d;
   logic [31:0]      din_q, din_d;
   logic [15:0]      pend_mask;
   logic             full, empty, starved;
   logic             alu_fire, push, pop;

   logic [3:0]       dest_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];

   assign wr_idx    = wr_ptr_q[AW-1:0];
   assign rd_idx    = rd_ptr_q[AW-1:0];
   assign occupancy = wr_ptr_q - rd_ptr_q;
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   // Starved: the ALU is held off for exactly this cycle so the head drains.
   assign starved   = (starve_q == CW'(STARVE_LIMIT));

   assign alu_fire  = bus.alu_valid && !starved;
   assign push      = bus.ld_valid && !full;
   assign pop       = !alu_fire && !empty;

   assign bus.alu_ready = !starved;
   assign bus.ld_ready  = !full;
   assign bus.wb_en     = wb_en_q;
   assign bus.dest      = dest_q;
   assign bus.Din       = din_q;
   assign bus.pend_mask = pend_mask;

   // An entry is live when its distance from the read pointer is inside the occupancy.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] offset;
      assign offset       = AW'(gi) - rd_idx;
      assign live[gi]     = ({1'b0, offset} < occupancy);
      assign dest_hit[gi] = live[gi] && (dest_mem[gi] == bus.alu_dest);
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i] && !kill_q[i]) begin
            pend_mask[dest_mem[i]] = 1'b1;
         end
      end
   end

   // Queued loads are older than any ALU result arriving now, so a matching
   // ALU write supersedes them, including a load pushed in the same cycle.
   always_comb begin
      kill_d = kill_q;
      if (alu_fire) begin
         kill_d = kill_q | dest_hit;
      end
      if (push) begin
         kill_d[wr_idx] = alu_fire && (bus.alu_dest == bus.ld_dest);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   always_comb begin
      starve_d = starve_q;
      if (pop || empty) begin
         starve_d = '0;
      end else if (alu_fire) begin
         starve_d = starve_q + CW'(1);
      end
   end

   // A killed head still consumes its grant but produces no write; address/data hold.
   always_comb begin
      wb_en_d = 1'b0;
      dest_d  = dest_q;
      din_d   = din_q;
      if (alu_fire) begin
         wb_en_d = 1'b1;
         dest_d  = bus.alu_dest;
         din_d   = bus.alu_data;
      end else if (pop && !kill_q[rd_idx]) begin
         wb_en_d = 1'b1;
         dest_d  = dest_mem[rd_idx];
         din_d   = data_mem[rd_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         kill_q   <= '0;
         starve_q <= '0;
         wb_en_q  <= 1'b0;
         dest_q   <= '0;
         din_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         kill_q   <= kill_d;
         starve_q <= starve_d;
         wb_en_q  <= wb_en_d;
         dest_q   <= dest_d;
         din_q    <= din_d;
      end
   end

   // Payload storage needs no reset: liveness comes only from the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         dest_mem[wr_idx] <= bus.ld_dest;
         data_mem[wr_idx] <= bus.ld_data;
      end
   end

   a_starve_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
      starved |-> !empty);
   a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
      occupancy <= (AW+1)'(DEPTH));
   a_starve_bound: assert property (@(posedge clk) disable iff (!rst_n)
      starve_q <= CW'(STARVE_LIMIT));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized + directed bench for writeback_arbiter: a queue-based reference model
// predicts each write; a negedge monitor pops and compares what the DUT presents.
module tb_writeback_arbiter;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   typedef struct {
      logic [3:0]  d;
      logic [31:0] v;
      bit          killed;
   } ld_t;

   typedef struct {
      int          c;
      logic [3:0]  d;
      logic [31:0] v;
   } wr_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_vec;
   int   n_err;

   ld_t  lq[$];
   wr_t  sb[$];
   int   starve;
   logic [3:0]  last_d;
   logic [31:0] last_v;

   writeback_arbiter_if bus ();

   writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one arbitration decision per cycle from the spec's rules.
   task automatic model_cycle(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                              input logic lv, input logic [3:0] lde, input logic [31:0] ldat);
      bit          exp_ar, exp_lr, afire, push, was_empty, popped;
      logic [15:0] exp_pm;
      ld_t         h;
      ld_t         n;
      wr_t         w;
      exp_ar = (starve != LIMIT);
      exp_lr = (lq.size() < DEPTH);
      exp_pm = '0;
      for (int i = 0; i < lq.size(); i++) begin
         if (!lq[i].killed) exp_pm[lq[i].d] = 1'b1;
      end
      chk("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
      chk("ld_ready",  32'(bus.ld_ready),  32'(exp_lr));
      chk("pend_mask", 32'(bus.pend_mask), 32'(exp_pm));

      afire     = av && exp_ar;
      push      = lv && exp_lr;
      was_empty = (lq.size() == 0);
      popped    = 1'b0;
      if (afire) begin
         w.c = cyc; w.d = ad; w.v = adat;
         sb.push_back(w);
         for (int i = 0; i < lq.size(); i++) begin
            if (lq[i].d == ad) lq[i].killed = 1'b1;
         end
      end else if (!was_empty) begin
         h = lq.pop_front();
         popped = 1'b1;
         if (!h.killed) begin
            w.c = cyc; w.d = h.d; w.v = h.v;
            sb.push_back(w);
         end
      end
      if (push) begin
         n.d = lde; n.v = ldat; n.killed = afire && (ad == lde);
         lq.push_back(n);
      end
      if (popped || was_empty) starve = 0;
      else if (afire) starve++;
   endtask

   task automatic step(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                       input logic lv, input logic [3:0] lde, input logic [31:0] ldat);
      @(negedge clk);
      bus.alu_valid = av;
      bus.alu_dest  = ad;
      bus.alu_data  = adat;
      bus.ld_valid  = lv;
      bus.ld_dest   = lde;
      bus.ld_data   = ldat;
      #1;
      model_cycle(av, ad, adat, lv, lde, ldat);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wb_en"},     32'(bus.wb_en),     32'd0);
      chk({tag, "_dest"},      32'(bus.dest),      32'd0);
      chk({tag, "_Din"},       bus.Din,            32'd0);
      chk({tag, "_pend_mask"}, 32'(bus.pend_mask), 32'd0);
      chk({tag, "_ld_ready"},  32'(bus.ld_ready),  32'd1);
      chk({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'd1);
   endtask

   // Monitor: every presented write must be the next predicted one, exactly one cycle after grant.
   always @(negedge clk) begin
      wr_t e;
      if (bus.wb_en === 1'b1) begin
         chk("wb_predicted", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_cycle", 32'(cyc), 32'(e.c + 1));
            chk("wb_dest",  32'(bus.dest), 32'(e.d));
            chk("wb_Din",   bus.Din, e.v);
            last_d = e.d;
            last_v = e.v;
            $display("wb cyc=%0d r%0d <= 0x%08h", cyc, bus.dest, bus.Din);
         end
      end else begin
         if (sb.size() != 0 && sb[0].c + 1 <= cyc) begin
            chk("wb_en", 32'(bus.wb_en), 32'd1);
            void'(sb.pop_front());
         end
         chk("hold_dest", 32'(bus.dest), 32'(last_d));
         chk("hold_Din",  bus.Din, last_v);
      end
   end

   initial begin
      n_vec = 0; n_err = 0; starve = 0;
      last_d = '0; last_v = '0;
      bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
      bus.ld_valid  = 1'b0; bus.ld_dest  = '0; bus.ld_data  = '0;
      rst_n = 1'b0;
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Loads only: r2 then r5 written on consecutive cycles.
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h11);
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h22);
      idle(3);

      // Busy ALU fills the FIFO; the starvation limit forces head pops.
      for (int i = 0; i < 16; i++)
         step(1'b1, 4'd1, 32'(1000 + i), 1'b1, 4'(8 + (i % 4)), 32'(2000 + i));
      idle(6);

      // Older load to r3 superseded by ALU write to r3.
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hAAAA);
      step(1'b1, 4'd3, 32'hBBBB, 1'b0, 4'd0, 32'd0);
      idle(3);

      // Same-cycle ALU and load to r7: load enters already killed.
      step(1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2);
      idle(3);

      // Pointer wrap: a chain of push/pop pairs through the FIFO.
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h500);
      for (int i = 0; i < 10; i++)
         step(1'b0, 4'd0, 32'd0, 1'b1, 4'(4 + (i % 3)), 32'(32'h501 + i));
      idle(3);

      // Asynchronous reset between clock edges with three loads queued behind a busy ALU.
      for (int i = 0; i < 4; i++)
         step(1'b1, 4'd1, $urandom, 1'b1, 4'(8 + i), $urandom);
      #1;
      rst_n = 1'b0;
      bus.alu_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      lq.delete(); sb.delete(); starve = 0;
      last_d = '0; last_v = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Random traffic; small register range provokes WAW kills, busy phases provoke starvation.
      for (int i = 0; i < 3000; i++) begin
         int pa;
         pa = ((i / 200) % 2 == 0) ? 50 : 92;
         step(1'($urandom_range(0, 99) < pa), 4'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 99) < 55), 4'($urandom_range(0, 3)), $urandom);
      end
      idle(DEPTH + 4);
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
